// File: rtl/regfile_operand_stage.sv
// rtl/regfile_operand_stage.sv - register file with registered two-operand issue to the logic units
module regfile_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] reg_s1,
    output logic [DATA_WIDTH-1:0] reg_s2,
    output logic                  enable
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Entry 0 is never written and is masked on read, so it reduces to constant zero.
    logic [DATA_WIDTH-1:0] regs [DEPTH];

    logic                  wr_live;
    logic [DATA_WIDTH-1:0] s1_next;
    logic [DATA_WIDTH-1:0] s2_next;

    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Forward write-back data to a same-cycle read so the operand never sees a stale value.
    always_comb begin
        s1_next = regs[rs1_addr];
        if (rs1_addr == '0) begin
            s1_next = '0;
        end else if (wr_live && (wr_addr == rs1_addr)) begin
            s1_next = wr_data;
        end
    end

    always_comb begin
        s2_next = regs[rs2_addr];
        if (rs2_addr == '0) begin
            s2_next = '0;
        end else if (wr_live && (wr_addr == rs2_addr)) begin
            s2_next = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_s1 <= '0;
            reg_s2 <= '0;
            enable <= 1'b0;
        end else begin
            enable <= rd_en;
            if (rd_en) begin
                reg_s1 <= s1_next;
                reg_s2 <= s2_next;
            end
        end
    end

endmodule

// File: tb/tb_regfile_operand_stage.sv
// tb/tb_regfile_operand_stage.sv - directed vector bench for regfile_operand_stage
module tb_regfile_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] reg_s1;
    logic [31:0] reg_s2;
    logic        enable;

    int errors = 0;
    int checks = 0;

    regfile_operand_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .reg_s1   (reg_s1),
        .reg_s2   (reg_s2),
        .enable   (enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        een;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic wr, logic [4:0] wa, logic [31:0] wd,
                                logic [31:0] e1, logic [31:0] e2, logic een);
        vec_t v;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.wr = wr; v.wa = wa; v.wd = wd;
        v.e1 = e1; v.e2 = e2; v.een = een;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic wr, input logic [4:0] wa, input logic [31:0] wd);
        rd_en = rd; rs1_addr = rs1; rs2_addr = rs2;
        wr_en = wr; wr_addr = wa; wr_data = wd;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);

        // Table: inputs applied at a negedge, outputs checked at the following negedge.
        vecs.push_back(mk(0, 0, 0, 1,  5, 32'hDEADBEEF, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  9, 32'h0000FFFF, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 32'h0,        32'h0, 32'h0, 0));
        vecs.push_back(mk(1, 5, 9, 0,  0, 32'h0,        32'hDEADBEEF, 32'h0000FFFF, 1));
        vecs.push_back(mk(0, 0, 0, 0,  0, 32'h0,        32'hDEADBEEF, 32'h0000FFFF, 0));
        vecs.push_back(mk(1, 7, 7, 1,  7, 32'h12345678, 32'h12345678, 32'h12345678, 1));
        vecs.push_back(mk(1, 7, 7, 0,  0, 32'h0,        32'h12345678, 32'h12345678, 1));
        vecs.push_back(mk(0, 0, 0, 1,  0, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,        32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 0, 0, 1,  0, 32'hFFFFFFFF, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 5, 9, 0,  0, 32'h0,        32'hDEADBEEF, 32'h0000FFFF, 1));
        vecs.push_back(mk(0, 0, 0, 1,  5, 32'h00000001, 32'hDEADBEEF, 32'h0000FFFF, 0));
        vecs.push_back(mk(0, 0, 0, 1,  5, 32'h00000001, 32'hDEADBEEF, 32'h0000FFFF, 0));
        vecs.push_back(mk(0, 0, 0, 1,  5, 32'h00000001, 32'hDEADBEEF, 32'h0000FFFF, 0));
        vecs.push_back(mk(1, 5, 5, 0,  0, 32'h0,        32'h00000001, 32'h00000001, 1));
        vecs.push_back(mk(1, 5, 6, 1,  6, 32'h0000ABCD, 32'h00000001, 32'h0000ABCD, 1));
        vecs.push_back(mk(0, 0, 0, 1,  1, 32'h00000011, 32'h00000001, 32'h0000ABCD, 0));
        vecs.push_back(mk(0, 0, 0, 1,  2, 32'h00000022, 32'h00000001, 32'h0000ABCD, 0));
        vecs.push_back(mk(0, 0, 0, 1,  3, 32'h00000033, 32'h00000001, 32'h0000ABCD, 0));
        vecs.push_back(mk(0, 0, 0, 1,  4, 32'h00000044, 32'h00000001, 32'h0000ABCD, 0));
        vecs.push_back(mk(1, 1, 9, 0,  0, 32'h0,        32'h00000011, 32'h0000FFFF, 1));
        vecs.push_back(mk(1, 2, 9, 0,  0, 32'h0,        32'h00000022, 32'h0000FFFF, 1));
        vecs.push_back(mk(1, 3, 9, 0,  0, 32'h0,        32'h00000033, 32'h0000FFFF, 1));
        vecs.push_back(mk(1, 4, 9, 0,  0, 32'h0,        32'h00000044, 32'h0000FFFF, 1));
        vecs.push_back(mk(0, 0, 0, 1, 31, 32'h80000001, 32'h00000044, 32'h0000FFFF, 0));
        vecs.push_back(mk(1, 31, 7, 0, 0, 32'h0,        32'h80000001, 32'h12345678, 1));

        // Reset state before any clock edge.
        #2;
        check("reset_s1", reg_s1, 32'h0);
        check("reset_s2", reg_s2, 32'h0);
        check("reset_en", {31'h0, enable}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Give the outputs a non-zero value, then reset mid-cycle with traffic present.
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hA5A5A5A5);
        @(posedge clk); @(negedge clk);
        drive(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0);
        @(posedge clk); @(negedge clk);
        check("pre_reset_s1", reg_s1, 32'hA5A5A5A5);
        check("pre_reset_en", {31'h0, enable}, 32'h1);
        drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 32'h5A5A5A5A);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_s1", reg_s1, 32'h0);
        check("async_reset_s2", reg_s2, 32'h0);
        check("async_reset_en", {31'h0, enable}, 32'h0);
        @(posedge clk); @(negedge clk);
        check("held_reset_en", {31'h0, enable}, 32'h0);
        rst_n = 1'b1;

        // Every register reads zero after reset; the write during reset was lost.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 5'(32 - i), 1'b0, 5'd0, 32'h0);
            @(posedge clk); @(negedge clk);
            check($sformatf("post_reset_s1_r%0d", i), reg_s1, 32'h0);
            check($sformatf("post_reset_s2_r%0d", 32 - i), reg_s2, 32'h0);
            check($sformatf("post_reset_en_%0d", i), {31'h0, enable}, 32'h1);
        end

        foreach (vecs[k]) begin
            drive(vecs[k].rd, vecs[k].rs1, vecs[k].rs2, vecs[k].wr, vecs[k].wa, vecs[k].wd);
            @(posedge clk); @(negedge clk);
            check($sformatf("vec%0d_s1", k), reg_s1, vecs[k].e1);
            check($sformatf("vec%0d_s2", k), reg_s2, vecs[k].e2);
            check($sformatf("vec%0d_en", k), {31'h0, enable}, {31'h0, vecs[k].een});
        end

        // Enable drops after the last read and the operands hold.
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        @(posedge clk); @(negedge clk);
        check("tail_en", {31'h0, enable}, 32'h0);
        check("tail_s1", reg_s1, 32'h80000001);
        check("tail_s2", reg_s2, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_operand_stage.md
# regfile_operand_stage

- Register file plus operand-issue stage that sits directly upstream of the 32-bit bitwise logic units (OR/AND/XOR gate arrays).
- Holds 2^ADDR_WIDTH general-purpose registers, with register 0 hardwired to zero.
- Each cycle it accepts one write-back. On request, it reads two source registers into registered operand outputs.
- It drives the logic units' operand buses `reg_s1`/`reg_s2` and their `enable` input with one-cycle latency.
- Read-during-write to the same register is forwarded.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register and of the operand buses
- ADDR_WIDTH, 5, register index width; depth = 2^ADDR_WIDTH

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous, active-low reset
- rd_en  input  1  operand-read request for this cycle
- rs1_addr  input  ADDR_WIDTH  source-1 register index
- rs2_addr  input  ADDR_WIDTH  source-2 register index
- wr_en  input  1  write-back request
- wr_addr  input  ADDR_WIDTH  destination register index
- wr_data  input  DATA_WIDTH  write-back data
- reg_s1  output  DATA_WIDTH  registered source-1 operand to logic units
- reg_s2  output  DATA_WIDTH  registered source-2 operand to logic units
- enable  output  1  operand-valid strobe, drives logic-unit enable

## Operation
- **Storage:** array of 2^ADDR_WIDTH registers, each DATA_WIDTH bits.
  - Register 0 always reads 0.
  - Writes with wr_addr==0 are discarded; no storage is required for index 0.
- **Write:** on a rising clk edge with wr_en=1 and wr_addr!=0, the register at wr_addr takes wr_data. No other register changes.
- **Read:** on a rising clk edge with rd_en=1, each operand register is loaded independently:
  - If its index is 0, it loads 0.
  - Else, if wr_en=1 and wr_addr equals its index in the same cycle, it loads wr_data (write-through forwarding).
  - Otherwise it loads the stored register value.
  - enable is loaded with 1.
- **Idle:** on a rising edge with rd_en=0:
  - reg_s1 and reg_s2 hold their previous values.
  - enable is loaded with 0.
  - The write path operates independently of rd_en.
- **Same-index reads:** rs1_addr==rs2_addr is legal; both outputs receive the same value, including when that value is forwarded.
- **Reset (rst_n=0):** asynchronous and immediate, regardless of clk.
  - All storage registers are cleared to 0.
  - reg_s1=0, reg_s2=0, enable=0.
  - Writes and reads presented during reset are lost.
  - The first edge after rst_n rises behaves normally.
- **Arithmetic:** no arithmetic; values pass unmodified at full DATA_WIDTH. No sign extension, no truncation.

## Timing
- Read latency is 1 cycle: inputs sampled at edge N appear on reg_s1/reg_s2/enable after edge N. The outputs stay stable until the next edge with rd_en=1.
- Write latency is 1 cycle: the value is stored at edge N.
  - A read sampled at edge N sees it through forwarding.
  - A read at edge N+1 or later sees it from storage.
- enable is high for exactly one cycle per rd_en cycle. Back-to-back rd_en gives continuous enable with new operands every cycle.
- There is no backpressure; the downstream logic units consume operands in the cycle enable is high.
- Reset deassertion is synchronised externally. The block is not required to tolerate rst_n rising coincident with a clk edge.
- All outputs are driven directly from flops; no combinational path from inputs to outputs.

## Test plan
- **Reset state:** assert rst_n=0 mid-cycle with rd_en=1, wr_en=1 → outputs go to reg_s1=0, reg_s2=0, enable=0 immediately, without a clock edge. After release, reading indices 1..31 returns 0 for all.
- **Write then read:** write 0xDEADBEEF to r5 and 0x0000FFFF to r9. Two cycles later, read rs1=5, rs2=9 with rd_en=1 → one cycle later reg_s1=0xDEADBEEF, reg_s2=0x0000FFFF, enable=1 for exactly that cycle.
- **Forwarding:** in the same cycle, write 0x12345678 to r7 and read rs1=7, rs2=7 → next cycle both operands are 0x12345678. A following read of r7 with no write still returns 0x12345678.
- **Register 0:** write 0xFFFFFFFF to r0, then read rs1=0, rs2=0 → both 0. Also do the write and the read in the same cycle → both 0, with no forwarding.
- **Hold and enable pulse:** read r5/r9, then hold rd_en=0 for 3 cycles while writing r5=0x1 → reg_s1 stays 0xDEADBEEF and enable=0 during hold. The next read of r5 returns 0x1.
- **Back-to-back streaming:** issue rd_en on 4 consecutive cycles with rs1=1..4 (preloaded 0x11,0x22,0x33,0x44) → reg_s1 steps 0x11,0x22,0x33,0x44 on consecutive cycles with enable held high for 4 cycles, then low.
